hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline run-control and hazard-stall scheduler for the 5-stage MIPS core. It sits beside the forwarding unit and decides, every cycle, whether each pipeline register advances, holds or is flushed. Inputs are load-use and branch-operand hazards from ID/EX/MEM and run/step/halt commands from the debug unit. A run-state FSM gates the whole pipeline for free-run and single-step execution, and two counters report executed and stalled cycles.

## Interface
Parameters:
- REG_ADDR, 5, register-index width
- CNT_W, 32, cycle/stall counter width

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_run  in  1  level: free-run request from debug unit
- i_step  in  1  one-cycle pulse: advance pipeline exactly one cycle
- i_halt_W  in  1  HALT instruction present in WB
- i_instr_rs_D  in  REG_ADDR  rs of instruction in ID
- i_instr_rt_D  in  REG_ADDR  rt of instruction in ID
- i_branch_D  in  1  ID holds BEQ/BNE (uses rs and rt)
- i_jump_reg_D  in  1  ID holds JR/JALR (uses rs only)
- i_pc_src_D  in  1  branch/jump resolved taken in ID
- i_write_reg_E  in  REG_ADDR  destination register in EX
- i_reg_write_E  in  1  RegWrite in EX
- i_mem_to_reg_E  in  1  MemToReg (load) in EX
- i_write_reg_M  in  REG_ADDR  destination register in MEM
- i_mem_to_reg_M  in  1  MemToReg (load) in MEM
- o_pc_en  out  1  PC write enable
- o_if_id_en  out  1  IF/ID write enable
- o_flush_D  out  1  clear IF/ID (synchronous in that register)
- o_flush_E  out  1  insert bubble into ID/EX
- o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB
- o_state  out  2  FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALT
- o_halted  out  1  state == HALT
- o_cycle_cnt  out  CNT_W  cycles with pipeline advancing
- o_stall_cnt  out  CNT_W  advancing cycles that were stalls

## Operation
- FSM (registered):
  - IDLE: i_step → STEP; else i_run → RUN.
  - RUN: i_halt_W → HALT; else !i_run → IDLE.
  - STEP: i_halt_W → HALT; else → IDLE. STEP lasts exactly one cycle.
  - HALT: held until i_reset.
- adv = (state==RUN | state==STEP) & !i_halt_W. The pipeline freezes with HALT sitting in WB.
- Hazard terms (combinational), where match(x) means x != 0 and (x == rs_D or x == rt_D):
  - lw_stall = i_mem_to_reg_E & i_reg_write_E & match(i_write_reg_E).
  - br_stall = i_branch_D & ((i_reg_write_E & match(i_write_reg_E)) | (i_mem_to_reg_M & match(i_write_reg_M))).
  - For jr_stall, use the same terms as br_stall but compare rs_D only, qualified by i_jump_reg_D.
  - stall = lw_stall | br_stall | jr_stall.
- Outputs:
  - If !adv: every output enable and flush is 0.
  - If adv & stall: o_pc_en=0, o_if_id_en=0, o_flush_E=1, o_flush_D=0, o_pipe_en=1.
  - If adv & !stall: o_pc_en=1, o_if_id_en=1, o_flush_E=0, o_flush_D=i_pc_src_D, o_pipe_en=1.
  - i_pc_src_D is ignored while stalling, because the branch operands are not yet valid.
- Counters:
  - o_cycle_cnt += 1 on each adv cycle.
  - o_stall_cnt += 1 on each adv & stall cycle.
  - Both wrap modulo 2^CNT_W and both hold in IDLE and HALT.

## Timing
- Reset (synchronous): state=IDLE, both counters 0. Consequently o_pc_en=o_if_id_en=o_flush_D=o_flush_E=o_pipe_en=0, o_halted=0, o_state=00.
- Reset has priority over every input, including mid-RUN, mid-STEP and HALT. It returns to IDLE on the next edge.
- Enables and flushes are combinational from the current state and hazard inputs, so zero-latency: they act on the same edge.
- State, o_halted and the counters update one cycle after their cause.
- Step timing:
  - An i_step pulse in IDLE gives exactly one adv cycle, in the cycle after the pulse.
  - An i_step pulse while in STEP or RUN is ignored.
  - i_step and i_run both high in IDLE: step wins.
- A load-use hazard stalls for 1 cycle.
- A branch dependent on an ALU op in EX stalls for 1 cycle.
- A branch dependent on a load stalls for 2 cycles: first via EX, then via MEM.
- i_halt_W with i_run=0 in the same cycle: go to HALT (halt has priority).
- A stalled instruction in STEP mode consumes the step. The stall repeats on later steps until the hazard clears.

## Test plan
- Reset then idle: i_reset=1 for 2 cycles, then i_run=0. All enables 0, o_state=00 and counters 0 for 10 cycles.
- Load-use:
  - Setup: RUN; EX has lw $3 (mem_to_reg_E=1, reg_write_E=1, write_reg_E=3); ID has add rs=3.
  - Required: o_pc_en=0, o_if_id_en=0, o_flush_E=1 for exactly 1 cycle; o_stall_cnt increments by 1.
  - Repeat with write_reg_E=0: no stall.
- Branch after load:
  - Setup: beq rs=5 in ID; lw $5 in EX on cycle n, then in MEM on cycle n+1.
  - Required: stall on n and n+1, advance on n+2. i_pc_src_D=1 on n+2 gives o_flush_D=1; i_pc_src_D=1 during n or n+1 gives o_flush_D=0.
- Single step:
  - Setup: in IDLE, pulse i_step three times at 5-cycle spacing.
  - Required: exactly 3 adv cycles, o_cycle_cnt=3, o_state sequence 00→10→00 for each pulse.
- Halt:
  - Setup: RUN, assert i_halt_W.
  - Required: all enables 0 that same cycle; o_halted=1 next cycle. Dropping i_run or pulsing i_step leaves HALT; i_reset returns to IDLE with counters 0.
- Counter wrap: CNT_W=4, RUN without stall for 17 cycles → o_cycle_cnt=1.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline run-control and hazard-stall scheduler for the 5-stage MIPS core.
// Decides each cycle whether the PC and pipeline registers advance, hold or
// flush. A small run-state FSM gates the pipeline for free-run and
// single-step debugging. Two counters report advancing and stalled cycles.
module hazard_stall_ctrl #(
  parameter int REG_ADDR = 5,
  parameter int CNT_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic                i_step,
  input  logic                i_halt_W,
  input  logic [REG_ADDR-1:0] i_instr_rs_D,
  input  logic [REG_ADDR-1:0] i_instr_rt_D,
  input  logic                i_branch_D,
  input  logic                i_jump_reg_D,
  input  logic                i_pc_src_D,
  input  logic [REG_ADDR-1:0] i_write_reg_E,
  input  logic                i_reg_write_E,
  input  logic                i_mem_to_reg_E,
  input  logic [REG_ADDR-1:0] i_write_reg_M,
  input  logic                i_mem_to_reg_M,
  output logic                o_pc_en,
  output logic                o_if_id_en,
  output logic                o_flush_D,
  output logic                o_flush_E,
  output logic                o_pipe_en,
  output logic [1:0]          o_state,
  output logic                o_halted,
  output logic [CNT_W-1:0]    o_cycle_cnt,
  output logic [CNT_W-1:0]    o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } run_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  run_state_t       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;

  logic adv;
  logic lw_stall;
  logic br_stall;
  logic jr_stall;
  logic stall;
  logic rs_rt_hit_E;
  logic rs_rt_hit_M;
  logic rs_hit_E;
  logic rs_hit_M;

  // Register 0 is hard-wired to zero, so a write to it never creates a hazard.
  function automatic logic hits_rs_rt(
    input logic [REG_ADDR-1:0] dst,
    input logic [REG_ADDR-1:0] rs,
    input logic [REG_ADDR-1:0] rt
  );
    return (dst != '0) && ((dst == rs) || (dst == rt));
  endfunction

  // JR/JALR only read rs, so rt must not cause a false stall for them.
  function automatic logic hits_rs(
    input logic [REG_ADDR-1:0] dst,
    input logic [REG_ADDR-1:0] rs
  );
    return (dst != '0) && (dst == rs);
  endfunction

  // Hazard detection: compares the ID source operands against the EX and MEM
  // destinations. A branch after a load stalls twice, first via EX then via MEM.
  always_comb begin
    rs_rt_hit_E = hits_rs_rt(i_write_reg_E, i_instr_rs_D, i_instr_rt_D);
    rs_rt_hit_M = hits_rs_rt(i_write_reg_M, i_instr_rs_D, i_instr_rt_D);
    rs_hit_E    = hits_rs(i_write_reg_E, i_instr_rs_D);
    rs_hit_M    = hits_rs(i_write_reg_M, i_instr_rs_D);

    lw_stall = i_mem_to_reg_E & i_reg_write_E & rs_rt_hit_E;
    br_stall = i_branch_D &
               ((i_reg_write_E & rs_rt_hit_E) | (i_mem_to_reg_M & rs_rt_hit_M));
    jr_stall = i_jump_reg_D &
               ((i_reg_write_E & rs_hit_E) | (i_mem_to_reg_M & rs_hit_M));
    stall    = lw_stall | br_stall | jr_stall;
  end

  // The pipeline only moves in RUN or STEP, and freezes with HALT sitting in WB.
  always_comb begin
    adv = ((state == ST_RUN) || (state == ST_STEP)) && !i_halt_W;
  end

  // Enables and flushes are zero-latency so they act on the coming edge. While
  // stalling the branch operands are stale, so pc_src must not flush IF/ID.
  always_comb begin
    o_pc_en    = 1'b0;
    o_if_id_en = 1'b0;
    o_flush_D  = 1'b0;
    o_flush_E  = 1'b0;
    o_pipe_en  = 1'b0;
    if (adv) begin
      o_pipe_en = 1'b1;
      if (stall) begin
        o_flush_E = 1'b1;
      end else begin
        o_pc_en    = 1'b1;
        o_if_id_en = 1'b1;
        o_flush_D  = i_pc_src_D;
      end
    end
  end

  // Run-state FSM: step beats run in IDLE, halt beats everything but reset,
  // and HALT is sticky until reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_step) begin
            state <= ST_STEP;
          end else if (i_run) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_halt_W) begin
            state <= ST_HALT;
          end else if (!i_run) begin
            state <= ST_IDLE;
          end
        end
        ST_STEP: begin
          if (i_halt_W) begin
            state <= ST_HALT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Performance counters: count advancing cycles and the stalled subset, both
  // wrapping naturally at the counter width.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else if (adv) begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (stall) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

  assign o_state     = state;
  assign o_halted    = (state == ST_HALT);
  assign o_cycle_cnt = cycle_cnt;
  assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl. A second instance with 4-bit
// counters shares all inputs so counter wrap can be observed.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       reset;
  logic       run;
  logic       step;
  logic       halt_W;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic       branch_D;
  logic       jump_reg_D;
  logic       pc_src_D;
  logic [4:0] write_reg_E;
  logic       reg_write_E;
  logic       mem_to_reg_E;
  logic [4:0] write_reg_M;
  logic       mem_to_reg_M;

  logic        pc_en, if_id_en, flush_D, flush_E, pipe_en, halted;
  logic [1:0]  state;
  logic [31:0] cycle_cnt, stall_cnt;

  logic        w_pc_en, w_if_id_en, w_flush_D, w_flush_E, w_pipe_en, w_halted;
  logic [1:0]  w_state;
  logic [3:0]  w_cycle_cnt, w_stall_cnt;

  int checkCount = 0;
  int errorCount = 0;

  hazard_stall_ctrl #(.REG_ADDR(5), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_step(step), .i_halt_W(halt_W),
    .i_instr_rs_D(rs_D), .i_instr_rt_D(rt_D), .i_branch_D(branch_D),
    .i_jump_reg_D(jump_reg_D), .i_pc_src_D(pc_src_D),
    .i_write_reg_E(write_reg_E), .i_reg_write_E(reg_write_E),
    .i_mem_to_reg_E(mem_to_reg_E), .i_write_reg_M(write_reg_M),
    .i_mem_to_reg_M(mem_to_reg_M),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_flush_D(flush_D),
    .o_flush_E(flush_E), .o_pipe_en(pipe_en), .o_state(state),
    .o_halted(halted), .o_cycle_cnt(cycle_cnt), .o_stall_cnt(stall_cnt)
  );

  hazard_stall_ctrl #(.REG_ADDR(5), .CNT_W(4)) dutWrap (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_step(step), .i_halt_W(halt_W),
    .i_instr_rs_D(rs_D), .i_instr_rt_D(rt_D), .i_branch_D(branch_D),
    .i_jump_reg_D(jump_reg_D), .i_pc_src_D(pc_src_D),
    .i_write_reg_E(write_reg_E), .i_reg_write_E(reg_write_E),
    .i_mem_to_reg_E(mem_to_reg_E), .i_write_reg_M(write_reg_M),
    .i_mem_to_reg_M(mem_to_reg_M),
    .o_pc_en(w_pc_en), .o_if_id_en(w_if_id_en), .o_flush_D(w_flush_D),
    .o_flush_E(w_flush_E), .o_pipe_en(w_pipe_en), .o_state(w_state),
    .o_halted(w_halted), .o_cycle_cnt(w_cycle_cnt), .o_stall_cnt(w_stall_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Enables packed as {pc_en, if_id_en, flush_D, flush_E, pipe_en}.
  task automatic checkEnables(input string tag, input logic [4:0] expected);
    checkOutput(tag, {27'd0, pc_en, if_id_en, flush_D, flush_E, pipe_en},
                {27'd0, expected});
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic br, input logic jr, input logic pcs,
                               input logic [4:0] wrE, input logic rwE,
                               input logic m2rE, input logic [4:0] wrM,
                               input logic m2rM);
    rs_D = rs; rt_D = rt; branch_D = br; jump_reg_D = jr; pc_src_D = pcs;
    write_reg_E = wrE; reg_write_E = rwE; mem_to_reg_E = m2rE;
    write_reg_M = wrM; mem_to_reg_M = m2rM;
    #1;
  endtask

  task automatic clearHazards();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tickClock();
    @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] EN_OFF   = 5'b00000;
  localparam logic [4:0] EN_ADV   = 5'b11001;
  localparam logic [4:0] EN_STALL = 5'b00011;
  localparam logic [4:0] EN_FLUSH = 5'b11101;

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_W = 1'b0;
    clearHazards();
    tickClock();
    tickClock();
    reset = 1'b0;
    clearHazards();

    // Reset then idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      checkEnables("idle_en", EN_OFF);
      checkOutput("idle_state", {30'd0, state}, 32'd0);
      checkOutput("idle_cycle", cycle_cnt, 32'd0);
      checkOutput("idle_stall", stall_cnt, 32'd0);
      checkOutput("idle_halted", {31'd0, halted}, 32'd0);
      tickClock();
    end

    // Enter RUN.
    run = 1'b1;
    tickClock();
    clearHazards();
    checkOutput("run_state", {30'd0, state}, 32'd1);
    checkEnables("run_en", EN_ADV);

    // Load-use on rs: one stall cycle.
    applyStimulus(5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0);
    checkEnables("lw_stall", EN_STALL);
    tickClock();
    clearHazards();
    checkEnables("lw_after", EN_ADV);
    checkOutput("lw_stallcnt", stall_cnt, 32'd1);
    tickClock();
    // Load to $0 never stalls.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    checkEnables("lw_r0", EN_ADV);
    tickClock();
    checkOutput("lw_r0_cycle", cycle_cnt, 32'd3);
    checkOutput("lw_r0_stall", stall_cnt, 32'd1);
    // ALU result in EX feeding a non-branch: forwarding handles it.
    applyStimulus(5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    checkEnables("alu_nostall", EN_ADV);
    tickClock();

    // Branch after load: stall on n (EX) and n+1 (MEM), taken flush on n+2.
    applyStimulus(5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    checkEnables("br_ld_n", EN_STALL);
    tickClock();
    applyStimulus(5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    checkEnables("br_ld_n1", EN_STALL);
    tickClock();
    applyStimulus(5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkEnables("br_ld_n2", EN_FLUSH);
    tickClock();
    checkOutput("br_ld_cycle", cycle_cnt, 32'd7);
    checkOutput("br_ld_stall", stall_cnt, 32'd3);

    // Branch on rt with ALU producer in EX: one stall.
    applyStimulus(5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
    checkEnables("br_alu_rt", EN_STALL);
    tickClock();
    applyStimulus(5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkEnables("br_alu_after", EN_ADV);
    tickClock();

    // JR ignores rt, but a load in MEM writing rs stalls it.
    applyStimulus(5'd4, 5'd6, 1'b0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0);
    checkEnables("jr_rt_only", EN_ADV);
    tickClock();
    applyStimulus(5'd4, 5'd6, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1);
    checkEnables("jr_rs_ldM", EN_STALL);
    tickClock();
    checkOutput("jr_stallcnt", stall_cnt, 32'd5);

    // Drop run: current cycle still advances, then IDLE.
    clearHazards();
    run = 1'b0;
    #1;
    checkEnables("run_drop_en", EN_ADV);
    tickClock();
    checkOutput("drop_state", {30'd0, state}, 32'd0);
    checkEnables("drop_en", EN_OFF);
    checkOutput("drop_cycle", cycle_cnt, 32'd12);

    // Three single steps at 5-cycle spacing.
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      #1;
      checkEnables("step_pulse_en", EN_OFF);
      tickClock();
      step = 1'b0;
      #1;
      checkOutput("step_state", {30'd0, state}, 32'd2);
      checkEnables("step_en", EN_ADV);
      tickClock();
      checkOutput("step_back", {30'd0, state}, 32'd0);
      for (int k = 0; k < 3; k++) begin
        checkEnables("step_gap_en", EN_OFF);
        tickClock();
      end
    end
    checkOutput("step_cycle", cycle_cnt, 32'd15);

    // Step and run together in IDLE: step wins, then RUN follows.
    step = 1'b1; run = 1'b1;
    tickClock();
    step = 1'b0;
    #1;
    checkOutput("steprun_state", {30'd0, state}, 32'd2);
    tickClock();
    checkOutput("steprun_idle", {30'd0, state}, 32'd0);
    tickClock();
    checkOutput("steprun_run", {30'd0, state}, 32'd1);
    step = 1'b1;
    tickClock();
    step = 1'b0;
    #1;
    checkOutput("step_in_run", {30'd0, state}, 32'd1);
    checkOutput("step_in_run_cyc", cycle_cnt, 32'd17);
    run = 1'b0;
    tickClock();

    // A stalled step consumes the step.
    step = 1'b1;
    tickClock();
    step = 1'b0;
    applyStimulus(5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0);
    checkEnables("step_stall_en", EN_STALL);
    tickClock();
    clearHazards();
    checkOutput("step_stall_st", {30'd0, state}, 32'd0);
    checkOutput("step_stall_cnt", stall_cnt, 32'd6);
    checkOutput("step_stall_cyc", cycle_cnt, 32'd19);

    // Halt in WB with run dropped the same cycle.
    run = 1'b1;
    tickClock();
    halt_W = 1'b1; run = 1'b0;
    #1;
    checkEnables("halt_en_same", EN_OFF);
    checkOutput("halt_not_yet", {31'd0, halted}, 32'd0);
    tickClock();
    halt_W = 1'b0;
    #1;
    checkOutput("halted", {31'd0, halted}, 32'd1);
    checkOutput("halt_state", {30'd0, state}, 32'd3);
    step = 1'b1;
    tickClock();
    step = 1'b0;
    run = 1'b1;
    tickClock();
    checkOutput("halt_sticky", {30'd0, state}, 32'd3);
    checkEnables("halt_en", EN_OFF);
    checkOutput("halt_cycle", cycle_cnt, 32'd19);
    reset = 1'b1;
    tickClock();
    reset = 1'b0;
    run = 1'b0;
    #1;
    checkOutput("halt_rst_state", {30'd0, state}, 32'd0);
    checkOutput("halt_rst_cycle", cycle_cnt, 32'd0);
    checkOutput("halt_rst_stall", stall_cnt, 32'd0);

    // Reset mid-RUN has priority over run.
    run = 1'b1;
    tickClock();
    tickClock();
    reset = 1'b1;
    tickClock();
    reset = 1'b0;
    run = 1'b0;
    #1;
    checkOutput("rst_run_state", {30'd0, state}, 32'd0);
    checkOutput("rst_run_cycle", cycle_cnt, 32'd0);

    // Counter wrap: 17 advancing cycles on a 4-bit counter reads 1.
    run = 1'b1;
    tickClock();
    for (int i = 0; i < 17; i++) tickClock();
    checkOutput("wrap_cycle", {28'd0, w_cycle_cnt}, 32'd1);
    checkOutput("wrap_main", cycle_cnt, 32'd17);
    checkOutput("wrap_stall", {28'd0, w_stall_cnt}, 32'd0);
    run = 1'b0;
    tickClock();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
